// File: rtl/fir_mac_sequencer.sv
// Time-shared FIR sequencer: drives one external fix14 multiplier, one tap per clock, and accumulates the products.
// Output reduction: define FIR_SAT_EN to clamp to the signed D_W range; otherwise the accumulator is truncated.
module fir_mac_sequencer #(
  parameter int D_W     = 16,
  parameter int N_TAPS  = 8,
  parameter int ACC_W   = 24,
  parameter int MUL_LAT = 0
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [D_W-1:0]            s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      coef_we,
  input  logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [D_W-1:0]            coef_data,
  input  logic                      buf_clr,
  output logic                      busy,
  output logic                      mul_ce,
  output logic [D_W-1:0]            mul_a,
  output logic [D_W-1:0]            mul_b,
  input  logic [D_W-1:0]            mul_p,
  output logic [D_W-1:0]            y_data,
  output logic                      y_valid,
  input  logic                      y_ready
);

  localparam int AW       = $clog2(N_TAPS);
  localparam int LAST_ACC = N_TAPS + MUL_LAT;
  localparam int CW       = $clog2(LAST_ACC + 2) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DRAIN, ST_OUT} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              cyc_q, cyc_d;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [N_TAPS-1:0][D_W-1:0] smp_q, smp_d;
  logic [N_TAPS-1:0][D_W-1:0] coef_q, coef_d;
  logic                       mul_ce_q, mul_ce_d;
  logic [D_W-1:0]             mul_a_q, mul_a_d;
  logic [D_W-1:0]             mul_b_q, mul_b_d;
  logic [D_W-1:0]             y_data_q, y_data_d;
  logic                       y_valid_q, y_valid_d;
  logic [AW-1:0]              rd_idx;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  function automatic logic [D_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
    if (a > SAT_MAX)      reduce_acc = {1'b0, {(D_W-1){1'b1}}};
    else if (a < SAT_MIN) reduce_acc = {1'b1, {(D_W-1){1'b0}}};
    else                  reduce_acc = a[D_W-1:0];
`else
    reduce_acc = a[D_W-1:0];
`endif
  endfunction

  // Tap k reads the sample written k acceptances ago.
  assign rd_idx = wr_ptr_q - cyc_q[AW-1:0];

  // A clear in the same cycle as a sample wins, so the sample is not offered a handshake.
  assign s_ready = (state_q == ST_IDLE) && sys_rst_n && !buf_clr;
  assign busy    = (state_q != ST_IDLE);
  assign mul_ce  = mul_ce_q;
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign y_data  = y_data_q;
  assign y_valid = y_valid_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= '0;
      wr_ptr_q  <= '0;
      acc_q     <= '0;
      smp_q     <= '0;
      coef_q    <= '0;
      mul_ce_q  <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      wr_ptr_q  <= wr_ptr_d;
      acc_q     <= acc_d;
      smp_q     <= smp_d;
      coef_q    <= coef_d;
      mul_ce_q  <= mul_ce_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    wr_ptr_d  = wr_ptr_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    coef_d    = coef_q;
    mul_ce_d  = 1'b0;
    mul_a_d   = '0;
    mul_b_d   = '0;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (coef_we) coef_d[coef_addr] = coef_data;
        if (buf_clr) begin
          smp_d    = '0;
          wr_ptr_d = '0;
        end else if (s_valid) begin
          smp_d[wr_ptr_q] = s_data;
          acc_d           = '0;
          cyc_d           = '0;
          state_d         = ST_MAC;
        end
      end
      // cyc_q counts edges after acceptance: the edge taken with cyc_q == c is E(c+1).
      ST_MAC, ST_DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q < CW'(N_TAPS)) begin
          mul_a_d = smp_q[rd_idx];
          mul_b_d = coef_q[cyc_q[AW-1:0]];
        end
        mul_ce_d = (cyc_q < CW'(LAST_ACC));
        if (cyc_q >= CW'(1 + MUL_LAT) && cyc_q <= CW'(LAST_ACC))
          acc_d = acc_q + {{(ACC_W-D_W){mul_p[D_W-1]}}, mul_p};
        if (cyc_q == CW'(N_TAPS - 1)) state_d = ST_DRAIN;
        if (cyc_q == CW'(LAST_ACC + 1)) begin
          y_data_d  = reduce_acc(acc_q);
          y_valid_d = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (y_ready) begin
          y_valid_d = 1'b0;
          wr_ptr_d  = wr_ptr_q + AW'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against a sum-of-products reference filter.
module tb_fir_mac_sequencer;

  localparam int N = 8;

  logic        sys_clk, sys_rst_n;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        buf_clr, busy, mul_ce;
  logic [15:0] mul_a, mul_b, mul_p, y_data;
  logic        y_valid, y_ready;

  int n_cmp = 0;
  int n_fail = 0;

  fir_mac_sequencer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .buf_clr(buf_clr), .busy(busy), .mul_ce(mul_ce),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // fix14 product as delivered by the external multiplier (also used by the reference)
  function automatic logic [15:0] fix14(input logic signed [15:0] a, input logic signed [15:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 14;
    return p[15:0];
  endfunction

  assign mul_p = fix14(mul_a, mul_b);

  // Reference: coefficient table plus the last N accepted samples, newest first.
  logic [15:0] coef_m [N];
  logic [15:0] hist [$];

  function automatic void model_clear_hist();
    hist.delete();
    for (int k = 0; k < N; k++) hist.push_back(16'h0000);
  endfunction

  function automatic void model_push(input logic [15:0] x);
    hist.push_front(x);
    void'(hist.pop_back());
  endfunction

  function automatic logic [15:0] model_out();
    longint acc;
    logic [15:0] p;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      p = fix14(hist[k], coef_m[k]);
      acc += longint'($signed(p));
    end
`ifdef FIR_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`endif
    return acc[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_coef(input int a, input logic [15:0] d);
    @(negedge sys_clk);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = d;
    @(negedge sys_clk);
    coef_we = 1'b0;
    coef_m[a] = d;
  endtask

  // One sample through the filter with y_ready high. Optional coefficient write in the
  // acceptance cycle, optional coefficient write + clear attempts while busy.
  task automatic run_sample(input logic [15:0] x, input bit cw, input int ca, input logic [15:0] cd,
                            input bit poke, output logic [15:0] y);
    int lat;
    bit seen;
    logic [15:0] exp;
    if (cw) coef_m[ca] = cd;
    model_push(x);
    exp = model_out();
    @(negedge sys_clk);
    s_data = x; s_valid = 1'b1;
    if (cw) begin coef_we = 1'b1; coef_addr = 3'(ca); coef_data = cd; end
    #1 chk("s_ready_idle", 32'(s_ready), 32'd1);
    @(posedge sys_clk); #1;
    s_valid = 1'b0; coef_we = 1'b0;
    chk("busy_mac", 32'(busy), 32'd1);
    chk("s_ready_mac", 32'(s_ready), 32'd0);
    if (poke) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h7FFF; buf_clr = 1'b1;
    end
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge sys_clk); lat++; #1;
      if (lat == 4) begin coef_we = 1'b0; buf_clr = 1'b0; end
      if (y_valid) seen = 1'b1;
    end
    coef_we = 1'b0; buf_clr = 1'b0;
    chk("latency", 32'(lat), 32'd10);
    chk("y_data", 32'(y_data), 32'(exp));
    y = y_data;
    $display("sample %h -> y_data %h (ref %h) latency %0d", x, y_data, exp, lat);
    @(posedge sys_clk); #1;
    chk("y_valid_drop", 32'(y_valid), 32'd0);
    chk("s_ready_back", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] y, exp_c, x;
    int lat;
    bit seen;

    sys_rst_n = 1'b0; s_data = '0; s_valid = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; buf_clr = 1'b0; y_ready = 1'b1;
    for (int k = 0; k < N; k++) coef_m[k] = 16'h0000;
    model_clear_hist();

    // Reset state
    #13;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_ce", 32'(mul_ce), 32'd0);
    chk("rst_mul_ab", {mul_a, mul_b}, 32'd0);
    chk("rst_y", {15'd0, y_valid, y_data}, 32'd0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    #1 chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Impulse
    for (int k = 0; k < N; k++) write_coef(k, 16'(16'h0100 * (k + 1)));
    for (int n = 0; n < N; n++) begin
      run_sample((n == 0) ? 16'h4000 : 16'h0000, 1'b0, 0, 16'h0, 1'b0, y);
      chk("impulse", 32'(y), 32'(16'h0100 * (n + 1)));
    end

    // Saturation
    for (int k = 0; k < N; k++) write_coef(k, 16'h4000);
    for (int n = 0; n < N; n++) run_sample(16'h7FFF, 1'b0, 0, 16'h0, 1'b0, y);
`ifdef FIR_SAT_EN
    exp_c = 16'h7FFF;
`else
    exp_c = 16'hFFF8;
`endif
    chk("sat_pos", 32'(y), 32'(exp_c));
    for (int n = 0; n < N; n++) run_sample(16'h8000, 1'b0, 0, 16'h0, 1'b0, y);
`ifdef FIR_SAT_EN
    exp_c = 16'h8000;
`else
    exp_c = 16'h0000;
`endif
    chk("sat_neg", 32'(y), 32'(exp_c));

    // Random coefficients and samples, some with a same-cycle coefficient write
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) write_coef(k, 16'($urandom));
      for (int n = 0; n < 10; n++)
        run_sample(16'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)),
                   16'($urandom), 1'b0, y);
    end

    // Backpressure
    x = 16'($urandom);
    model_push(x);
    exp_c = model_out();
    @(negedge sys_clk); s_data = x; s_valid = 1'b1;
    @(posedge sys_clk); #1; s_valid = 1'b0; y_ready = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge sys_clk); lat++; #1;
      if (y_valid) seen = 1'b1;
    end
    chk("bp_latency", 32'(lat), 32'd10);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'($urandom);
      @(posedge sys_clk); #1;
      chk("bp_y_data", 32'(y_data), 32'(exp_c));
      chk("bp_hold", {29'd0, y_valid, s_ready, mul_ce}, 32'b100);
    end
    s_valid = 1'b0; y_ready = 1'b1;
    @(posedge sys_clk); #1;
    chk("bp_release", {30'd0, y_valid, s_ready}, 32'b01);
    $display("backpressure sample %h -> y_data %h held 5 cycles", x, exp_c);
    run_sample(16'($urandom), 1'b0, 0, 16'h0, 1'b0, y);

    // Coefficient write and clear while busy are ignored
    run_sample(16'($urandom), 1'b0, 0, 16'h0, 1'b1, y);
    run_sample(16'($urandom), 1'b0, 0, 16'h0, 1'b0, y);

    // Clear collides with a sample: clear wins
    @(negedge sys_clk); buf_clr = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    @(posedge sys_clk); #1;
    buf_clr = 1'b0; s_valid = 1'b0;
    chk("clr_vs_sample_busy", 32'(busy), 32'd0);
    model_clear_hist();
    $display("buf_clr with s_valid: busy=%0d", busy);
    x = 16'($urandom);
    run_sample(x, 1'b0, 0, 16'h0, 1'b0, y);
    chk("clr_collide_out", 32'(y), 32'(fix14(x, coef_m[0])));

    // Clear after a filled history
    for (int n = 0; n < 6; n++) run_sample(16'($urandom), 1'b0, 0, 16'h0, 1'b0, y);
    @(negedge sys_clk); buf_clr = 1'b1;
    @(negedge sys_clk); buf_clr = 1'b0;
    model_clear_hist();
    x = 16'($urandom);
    run_sample(x, 1'b0, 0, 16'h0, 1'b0, y);
    chk("clear_out", 32'(y), 32'(fix14(x, coef_m[0])));

    // Reset at tap 3
    @(negedge sys_clk); s_data = 16'($urandom); s_valid = 1'b1;
    @(posedge sys_clk); #1; s_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {28'd0, s_ready, busy, mul_ce, y_valid}, 32'd0);
    chk("midrst_mul_ab", {mul_a, mul_b}, 32'd0);
    chk("midrst_y_data", 32'(y_data), 32'd0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    #1 chk("midrst_s_ready", 32'(s_ready), 32'd1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge sys_clk); #1;
      if (y_valid) seen = 1'b1;
    end
    chk("midrst_no_yvalid", 32'(seen), 32'd0);
    $display("reset mid-MAC: y_valid seen afterwards=%0d", seen);
    for (int k = 0; k < N; k++) coef_m[k] = 16'h0000;
    model_clear_hist();
    run_sample(16'h7FFF, 1'b0, 0, 16'h0, 1'b0, y);
    chk("midrst_coef_zero", 32'(y), 32'd0);
    for (int k = 0; k < N; k++) write_coef(k, 16'($urandom));
    for (int n = 0; n < 5; n++) run_sample(16'($urandom), 1'b0, 0, 16'h0, 1'b0, y);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
